// File: rtl/lcd_bus_sequencer.sv
// 8080-style LCD write-bus owner: panel reset sequence, then cfg/pixel arbitration
// with command-sequence locking and two-byte RGB565 pixel transfers.
module lcd_bus_sequencer #(
    parameter int RST_LOW_CYC  = 120,
    parameter int RST_WAIT_CYC = 1440000,
    parameter int WR_LOW_CYC   = 1,
    parameter int WR_HIGH_CYC  = 1
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_rs,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_last,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        init_done,
    output logic [7:0]  lcd_d,
    output logic        lcd_rst_n,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic [2:0]  dbg_state
);

    localparam int RST_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int CNT_MAX = (RST_MAX > 15) ? RST_MAX : 15;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LOW_LD  = CW'(RST_LOW_CYC - 1);
    localparam logic [CW-1:0] RST_WAIT_LD = CW'(RST_WAIT_CYC - 1);
    localparam logic [CW-1:0] WR_LOW_LD   = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] WR_HIGH_LD  = CW'(WR_HIGH_CYC - 1);

    typedef enum logic [2:0] {
        S_RST_LOW  = 3'd0,
        S_RST_WAIT = 3'd1,
        S_IDLE     = 3'd2,
        S_WR_LOW   = 3'd3,
        S_WR_HIGH  = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          lock_q;
    logic          pend_q;
    logic [7:0]    byte2_q;
    logic          init_done_q;
    logic [7:0]    lcd_d_q;
    logic          lcd_rst_n_q;
    logic          cs_n_q;
    logic          rs_q;
    logic          wr_n_q;

    logic idle_rdy;
    logic cfg_fire;
    logic pix_fire;
    logic cnt_zero;

    // Handshake: a byte/pixel moves on the rising edge where valid and ready are both high.
    // Ready is combinational, only in IDLE after init; cfg wins, and a held lock starves pixels.
    assign idle_rdy  = (state_q == S_IDLE) && init_done_q;
    assign cfg_ready = idle_rdy;
    assign pix_ready = idle_rdy && !cfg_valid && !lock_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign pix_fire  = pix_valid && pix_ready;
    assign cnt_zero  = (cnt_q == '0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST_LOW;
            cnt_q       <= RST_LOW_LD;
            lock_q      <= 1'b0;
            pend_q      <= 1'b0;
            byte2_q     <= 8'h00;
            init_done_q <= 1'b0;
            lcd_d_q     <= 8'h00;
            lcd_rst_n_q <= 1'b0;
            cs_n_q      <= 1'b1;
            rs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
        end else begin
            case (state_q)
                S_RST_LOW: begin
                    if (cnt_zero) begin
                        state_q     <= S_RST_WAIT;
                        cnt_q       <= RST_WAIT_LD;
                        lcd_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RST_WAIT: begin
                    if (cnt_zero) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_IDLE: begin
                    if (cfg_fire) begin
                        state_q <= S_WR_LOW;
                        cnt_q   <= WR_LOW_LD;
                        lock_q  <= !cfg_last;
                        pend_q  <= 1'b0;
                        lcd_d_q <= cfg_data;
                        rs_q    <= cfg_rs;
                        cs_n_q  <= 1'b0;
                        wr_n_q  <= 1'b0;
                    end else if (pix_fire) begin
                        state_q <= S_WR_LOW;
                        cnt_q   <= WR_LOW_LD;
                        pend_q  <= 1'b1;
                        byte2_q <= pix_data[7:0];
                        lcd_d_q <= pix_data[15:8];
                        rs_q    <= 1'b1;
                        cs_n_q  <= 1'b0;
                        wr_n_q  <= 1'b0;
                    end
                end
                S_WR_LOW: begin
                    if (cnt_zero) begin
                        state_q <= S_WR_HIGH;
                        cnt_q   <= WR_HIGH_LD;
                        wr_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WR_HIGH: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (pend_q) begin
                        // Low pixel byte follows directly, chip select stays asserted.
                        state_q <= S_WR_LOW;
                        cnt_q   <= WR_LOW_LD;
                        pend_q  <= 1'b0;
                        lcd_d_q <= byte2_q;
                        wr_n_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        cs_n_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_RST_LOW;
                    cnt_q   <= RST_LOW_LD;
                end
            endcase
        end
    end

    assign init_done = init_done_q;
    assign lcd_d     = lcd_d_q;
    assign lcd_rst_n = lcd_rst_n_q;
    assign lcd_cs_n  = cs_n_q;
    assign lcd_rs    = rs_q;
    assign lcd_wr_n  = wr_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: scenario tasks plus a byte-level scoreboard fed
// from accepted handshakes and drained on every rising write strobe.
module tb_lcd_bus_sequencer;

    localparam int RST_LOW  = 4;
    localparam int RST_WAIT = 8;
    localparam int WL       = 1;
    localparam int WH       = 1;
    localparam int BYTE_CYC = WL + WH;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_rs = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_last = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [15:0] pix_data = 16'h0000;
    logic        init_done;
    logic [7:0]  lcd_d;
    logic        lcd_rst_n;
    logic        lcd_cs_n;
    logic        lcd_rs;
    logic        lcd_wr_n;
    logic [2:0]  dbg_state;

    always #5 clk_in = ~clk_in;

    lcd_bus_sequencer #(
        .RST_LOW_CYC (RST_LOW),
        .RST_WAIT_CYC(RST_WAIT),
        .WR_LOW_CYC  (WL),
        .WR_HIGH_CYC (WH)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_rs   (cfg_rs),
        .cfg_data (cfg_data),
        .cfg_last (cfg_last),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data (pix_data),
        .init_done(init_done),
        .lcd_d    (lcd_d),
        .lcd_rst_n(lcd_rst_n),
        .lcd_cs_n (lcd_cs_n),
        .lcd_rs   (lcd_rs),
        .lcd_wr_n (lcd_wr_n),
        .dbg_state(dbg_state)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [8:0] exp_q[$];
    int         pix_acc_cyc[$];
    int         pix_acc_n = 0;
    int         cfg_acc_n = 0;
    int         last_cfg_cyc = 0;
    logic       lock_m = 1'b0;
    int         wr_rises = 0;
    logic [7:0] last_exp = 8'h00;

    // Reference model: every accepted request becomes expected bus bytes in order.
    always @(posedge clk_in) begin
        if (!rst_n) begin
            lock_m = 1'b0;
        end else begin
            if (pix_valid && pix_ready) begin
                n_checks++;
                if (lock_m || cfg_valid) begin
                    n_fail++;
                    $display("FAIL pix_grant: pixel accepted with lock=%0d cfg_valid=%0d, required both 0", lock_m, cfg_valid);
                end
                exp_q.push_back({1'b1, pix_data[15:8]});
                exp_q.push_back({1'b1, pix_data[7:0]});
                pix_acc_n++;
                pix_acc_cyc.push_back(cyc);
            end
            if (cfg_valid && cfg_ready) begin
                exp_q.push_back({cfg_rs, cfg_data});
                cfg_acc_n++;
                last_cfg_cyc = cyc;
                lock_m = !cfg_last;
            end
        end
        cyc++;
    end

    always @(posedge lcd_wr_n) begin
        logic [8:0] e;
        if (rst_n) begin
            n_checks++;
            wr_rises++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_byte: unexpected write rs=%0b d=0x%02h, required no write", lcd_rs, lcd_d);
            end else begin
                e = exp_q.pop_front();
                last_exp = e[7:0];
                if ({lcd_rs, lcd_d} !== e || lcd_cs_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bus_byte: got rs=%0b d=0x%02h cs_n=%0b, required rs=%0b d=0x%02h cs_n=0",
                             lcd_rs, lcd_d, lcd_cs_n, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic send_cfg(input logic rs, input logic [7:0] d, input logic last);
        bit done = 1'b0;
        @(negedge clk_in);
        cfg_valid = 1'b1; cfg_rs = rs; cfg_data = d; cfg_last = last;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            done = cfg_ready;
            @(posedge clk_in);
            #1;
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL cfg_handshake: no acceptance within 40 cycles, required acceptance");
        end
    endtask

    task automatic send_pix(input logic [15:0] d);
        bit done = 1'b0;
        @(negedge clk_in);
        pix_valid = 1'b1; pix_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            done = pix_ready;
            @(posedge clk_in);
            #1;
        end
        pix_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL pix_handshake: no acceptance within 40 cycles, required acceptance");
        end
    endtask

    task automatic test_reset();
        logic exp_rst, exp_done;
        cfg_valid = 1'b1; pix_valid = 1'b1;
        #23;
        n_checks++;
        if (lcd_rst_n !== 1'b0 || lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_rs !== 1'b0 ||
            lcd_d !== 8'h00 || init_done !== 1'b0 || cfg_ready !== 1'b0 || pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: rst_n=%0b cs_n=%0b wr_n=%0b rs=%0b d=0x%02h done=%0b crdy=%0b prdy=%0b, required 0 1 1 0 0x00 0 0 0",
                     lcd_rst_n, lcd_cs_n, lcd_wr_n, lcd_rs, lcd_d, init_done, cfg_ready, pix_ready);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int k = 0; k < RST_LOW + RST_WAIT; k++) begin
            @(posedge clk_in);
            #1;
            exp_rst  = (k + 1 >= RST_LOW);
            exp_done = (k + 1 >= RST_LOW + RST_WAIT);
            n_checks++;
            if (lcd_rst_n !== exp_rst || init_done !== exp_done || cfg_ready !== exp_done ||
                pix_ready !== 1'b0 || lcd_cs_n !== 1'b1) begin
                n_fail++;
                $display("FAIL powerup edge %0d: rst_n=%0b done=%0b crdy=%0b prdy=%0b cs_n=%0b, required %0b %0b %0b 0 1",
                         k, lcd_rst_n, init_done, cfg_ready, pix_ready, lcd_cs_n, exp_rst, exp_done, exp_done);
            end
        end
        cfg_valid = 1'b0; pix_valid = 1'b0;
    endtask

    task automatic test_single_cmd();
        int   r0 = wr_rises;
        logic exp_cs, exp_wr;
        send_cfg(1'b0, 8'h2A, 1'b1);
        for (int i = 0; i < BYTE_CYC + 1; i++) begin
            @(negedge clk_in);
            exp_cs = (i < BYTE_CYC) ? 1'b0 : 1'b1;
            exp_wr = (i < WL) ? 1'b0 : 1'b1;
            n_checks++;
            if (lcd_cs_n !== exp_cs || lcd_wr_n !== exp_wr ||
                (i < BYTE_CYC && (lcd_d !== 8'h2A || lcd_rs !== 1'b0))) begin
                n_fail++;
                $display("FAIL single_cmd cycle %0d: cs_n=%0b wr_n=%0b d=0x%02h rs=%0b, required cs_n=%0b wr_n=%0b d=0x2A rs=0",
                         i, lcd_cs_n, lcd_wr_n, lcd_d, lcd_rs, exp_cs, exp_wr);
            end
        end
        n_checks++;
        if (wr_rises - r0 != 1) begin
            n_fail++;
            $display("FAIL single_cmd_strobes: %0d rising edges, required 1", wr_rises - r0);
        end
    endtask

    task automatic test_pixel();
        int         r0 = wr_rises;
        logic [15:0] px = 16'hF81F;
        logic       in_xfer, exp_wr;
        logic [7:0] exp_d;
        send_pix(px);
        for (int i = 0; i < 2 * BYTE_CYC + 1; i++) begin
            @(negedge clk_in);
            in_xfer = (i < 2 * BYTE_CYC);
            exp_d   = ((i / BYTE_CYC) == 0) ? px[15:8] : px[7:0];
            exp_wr  = in_xfer ? (((i % BYTE_CYC) < WL) ? 1'b0 : 1'b1) : 1'b1;
            n_checks++;
            if (lcd_cs_n !== !in_xfer || lcd_wr_n !== exp_wr ||
                (in_xfer && (lcd_d !== exp_d || lcd_rs !== 1'b1))) begin
                n_fail++;
                $display("FAIL pixel_split cycle %0d: cs_n=%0b wr_n=%0b d=0x%02h rs=%0b, required cs_n=%0b wr_n=%0b d=0x%02h rs=1",
                         i, lcd_cs_n, lcd_wr_n, lcd_d, lcd_rs, !in_xfer, exp_wr, exp_d);
            end
        end
        n_checks++;
        if (wr_rises - r0 != 2) begin
            n_fail++;
            $display("FAIL pixel_strobes: %0d rising edges, required 2", wr_rises - r0);
        end
    endtask

    task automatic test_back_to_back();
        int n0, seen;
        pix_acc_cyc.delete();
        n0 = pix_acc_n;
        seen = pix_acc_n;
        @(posedge clk_in);
        #1;
        pix_valid = 1'b1;
        pix_data = 16'($urandom);
        for (int i = 0; i < 100 && pix_acc_n - n0 < 6; i++) begin
            @(posedge clk_in);
            #1;
            if (pix_acc_n != seen) begin
                seen = pix_acc_n;
                pix_data = 16'($urandom);
            end
        end
        pix_valid = 1'b0;
        n_checks++;
        if (pix_acc_n - n0 < 6) begin
            n_fail++;
            $display("FAIL b2b_count: %0d pixels accepted, required 6", pix_acc_n - n0);
        end
        for (int k = 1; k < pix_acc_cyc.size(); k++) begin
            n_checks++;
            if (pix_acc_cyc[k] - pix_acc_cyc[k-1] != 2 * BYTE_CYC + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing: %0d cycles between pixels, required %0d",
                         pix_acc_cyc[k] - pix_acc_cyc[k-1], 2 * BYTE_CYC + 1);
            end
        end
        repeat (8) @(negedge clk_in);
    endtask

    task automatic test_priority_lock();
        int n0;
        @(posedge clk_in);
        #1;
        cfg_valid = 1'b1; cfg_rs = 1'b0; cfg_data = 8'h2A; cfg_last = 1'b0;
        pix_valid = 1'b1; pix_data = 16'($urandom);
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1 || pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL priority: cfg_ready=%0b pix_ready=%0b, required 1 0", cfg_ready, pix_ready);
        end
        @(posedge clk_in);
        #1;
        cfg_valid = 1'b0;
        n0 = pix_acc_n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            n_checks++;
            if (pix_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_hold cycle %0d: pix_ready=%0b, required 0", i, pix_ready);
            end
        end
        send_cfg(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20 && pix_acc_n == n0; i++) begin
            @(posedge clk_in);
            #1;
        end
        pix_valid = 1'b0;
        n_checks++;
        if (pix_acc_n != n0 + 1 || pix_acc_cyc[$] != last_cfg_cyc + BYTE_CYC + 1) begin
            n_fail++;
            $display("FAIL lock_release: %0d pixels, at cycle %0d, required 1 at cycle %0d",
                     pix_acc_n - n0, pix_acc_cyc[$], last_cfg_cyc + BYTE_CYC + 1);
        end
        repeat (8) @(negedge clk_in);
    endtask

    task automatic test_stall();
        int r0 = wr_rises;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            n_checks++;
            if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_d !== last_exp) begin
                n_fail++;
                $display("FAIL stall cycle %0d: cs_n=%0b wr_n=%0b d=0x%02h, required 1 1 0x%02h",
                         i, lcd_cs_n, lcd_wr_n, lcd_d, last_exp);
            end
        end
        n_checks++;
        if (wr_rises != r0) begin
            n_fail++;
            $display("FAIL stall_strobes: %0d rising edges, required 0", wr_rises - r0);
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_in);
            #1;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_rs    = 1'($urandom_range(0, 1));
            cfg_data  = 8'($urandom);
            cfg_last  = ($urandom_range(0, 2) != 0);
            pix_valid = 1'($urandom_range(0, 1));
            pix_data  = 16'($urandom);
        end
        @(posedge clk_in);
        #1;
        cfg_valid = 1'b0; pix_valid = 1'b0;
        send_cfg(1'b1, 8'($urandom), 1'b1);
        repeat (8) @(negedge clk_in);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d bytes never written, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_pixel();
        int r0, rise_k, done_k;
        send_pix(16'hF81F);
        @(posedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (lcd_rst_n !== 1'b0 || lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_rs !== 1'b0 ||
            lcd_d !== 8'h00 || init_done !== 1'b0 || cfg_ready !== 1'b0 || pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_values: rst_n=%0b cs_n=%0b wr_n=%0b rs=%0b d=0x%02h done=%0b crdy=%0b prdy=%0b, required 0 1 1 0 0x00 0 0 0",
                     lcd_rst_n, lcd_cs_n, lcd_wr_n, lcd_rs, lcd_d, init_done, cfg_ready, pix_ready);
        end
        exp_q.delete();
        r0 = wr_rises;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        rise_k = -1;
        done_k = -1;
        for (int k = 0; k < RST_LOW + RST_WAIT + 4; k++) begin
            @(posedge clk_in);
            #1;
            if (lcd_rst_n === 1'b1 && rise_k < 0) rise_k = k;
            if (init_done === 1'b1 && done_k < 0) done_k = k;
        end
        n_checks++;
        if (rise_k != RST_LOW - 1 || done_k != RST_LOW + RST_WAIT - 1) begin
            n_fail++;
            $display("FAIL midreset_sequence: lcd_rst_n rose at edge %0d, init_done at %0d, required %0d and %0d",
                     rise_k, done_k, RST_LOW - 1, RST_LOW + RST_WAIT - 1);
        end
        n_checks++;
        if (wr_rises != r0 || lcd_d !== 8'h00 || lcd_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_discard: %0d strobes d=0x%02h cs_n=%0b, required 0 strobes d=0x00 cs_n=1",
                     wr_rises - r0, lcd_d, lcd_cs_n);
        end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_pixel();
        test_back_to_back();
        test_priority_lock();
        test_stall();
        test_random_mix();
        test_reset_mid_pixel();
        $display("final state code %0d, %0d cfg and %0d pixel handshakes", dbg_state, cfg_acc_n, pix_acc_n);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_sequencer.md
# lcd_bus_sequencer

Owns the 8-bit 8080-style LCD write bus (lcd_d, lcd_rst_n, lcd_cs_n, lcd_rs, lcd_wr_n) between the clock/top level and the LCD pins. It runs the panel hardware-reset sequence after power-up, then arbitrates the bus between two requesters: a configuration/command port and the renderer's RGB565 pixel stream. It generates all write-strobe timing, keeps command sequences atomic, and emits each pixel as two bytes.

## Interface
- RST_LOW_CYC, 120: cycles lcd_rst_n is held low after reset release (about 10 µs at 12 MHz).
- RST_WAIT_CYC, 1440000: cycles to wait after lcd_rst_n rises before init_done (about 120 ms).
- WR_LOW_CYC, 1: cycles lcd_wr_n is low per byte (valid range 1..15).
- WR_HIGH_CYC, 1: cycles lcd_wr_n is high per byte after the rising edge (valid range 1..15).

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  a config byte is offered.
- cfg_ready  out  1  config byte accepted this cycle when cfg_valid is also high.
- cfg_rs  in  1  0 = command, 1 = parameter.
- cfg_data  in  8  config byte.
- cfg_last  in  1  final byte of a command sequence; releases the bus lock.
- pix_valid  in  1  a pixel is offered.
- pix_ready  out  1  pixel accepted this cycle when pix_valid is also high.
- pix_data  in  16  RGB565 pixel.
- init_done  out  1  reset sequence complete; sticky until rst_n.
- lcd_d  out  8  bus data.
- lcd_rst_n  out  1  panel reset, active low.
- lcd_cs_n  out  1  chip select, active low.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_wr_n  out  1  write strobe; the panel latches on the rising edge.

## Operation
- States: RST_LOW, RST_WAIT, IDLE, WR_LOW, WR_HIGH.
- RST_LOW: lcd_rst_n=0 for RST_LOW_CYC cycles, then go to RST_WAIT.
- RST_WAIT: lcd_rst_n=1 for RST_WAIT_CYC cycles, then set init_done=1 and go to IDLE. One down-counter serves both states, sized for the larger parameter.
- IDLE: cfg_ready and pix_ready are combinational, and are high only in IDLE with init_done=1, subject to the grant rules below.
- Grant rules:
  - cfg has fixed priority over pix.
  - Accepting cfg with cfg_last=0 sets lock. Accepting cfg with cfg_last=1 clears lock.
  - While lock=1, pix_ready=0 even if cfg_valid is low.
- Pixel transfers: an accepted pixel is latched and sent as pix_data[15:8] then pix_data[7:0], both with rs=1, as one atomic transfer. No cfg byte may interleave between the two bytes.
- Config transfers: an accepted cfg byte is latched and sent once with rs=cfg_rs.
- Byte cycle: WR_LOW for WR_LOW_CYC cycles (wr_n=0), then WR_HIGH for WR_HIGH_CYC cycles (wr_n=1).
  - After WR_HIGH, if a second pixel byte is pending, go to WR_LOW with the low byte. Otherwise go to IDLE.
- Bus levels:
  - lcd_cs_n=0 throughout WR_LOW/WR_HIGH of a transfer; lcd_cs_n=1 in IDLE and in reset states.
  - lcd_d and lcd_rs are registered, and stable from the first WR_LOW cycle through the last WR_HIGH cycle of each byte.
- Reset values (asynchronous, and also whenever rst_n goes low mid-operation):
  - lcd_rst_n=0, lcd_cs_n=1, lcd_wr_n=1, lcd_rs=0, lcd_d=0x00.
  - init_done=0, cfg_ready=0, pix_ready=0, lock=0, pending byte discarded, state RST_LOW.
  - The full panel reset sequence reruns after rst_n is released.

## Timing
- Handshake: the transfer occurs at the clock edge where valid&ready. The first WR_LOW cycle follows that edge, so lcd_d is valid one cycle after acceptance.
- Config byte: occupies WR_LOW_CYC+WR_HIGH_CYC cycles, plus 1 IDLE cycle before the next acceptance.
  - Defaults give 3 cycles per byte; lcd_cs_n returns high for one cycle between bytes.
- Pixel: occupies 2*(WR_LOW_CYC+WR_HIGH_CYC) cycles with lcd_cs_n low continuously, plus 1 IDLE cycle.
  - Defaults give 5 cycles per pixel.
- Ready signals: valid may be held high across cycles. Ready never asserts outside IDLE.
- Reset sequence: with rst_n released before edge 0, lcd_rst_n rises after RST_LOW_CYC edges.
  - init_done rises RST_WAIT_CYC edges after that.
  - The first ready can assert in the same cycle init_done is high.

## Test plan
All scenarios use RST_LOW_CYC=4, RST_WAIT_CYC=8, WR_LOW_CYC=1, WR_HIGH_CYC=1.
- Power-up: release rst_n -> lcd_rst_n=0 for 4 cycles then 1; init_done=1 exactly 8 cycles later; cfg_ready/pix_ready stay 0 before that even with valids high.
- Single command: cfg_valid, rs=0, data=0x2A, last=1 -> next cycle lcd_cs_n=0, lcd_rs=0, lcd_d=0x2A, lcd_wr_n=0 for 1 cycle, then wr_n=1 for 1 cycle, then cs_n=1; one rising wr_n edge.
- Pixel split: pix_data=0xF81F -> bytes 0xF8 then 0x1F with rs=1; two wr_n pulses; cs_n low for 4 contiguous cycles; back-to-back pixels accepted every 5 cycles.
- Priority and lock:
  - cfg_valid and pix_valid both high -> cfg accepted first.
  - Send cfg 0x2A (last=0), then drop cfg_valid with pix_valid high -> pix_ready stays 0.
  - Then send cfg 0x00 (last=1) -> pix accepted at the next IDLE.
- Reset mid-pixel: assert rst_n low during WR_HIGH of byte 0xF8 -> outputs take reset values asynchronously, byte 0x1F is never driven, init_done=0, and the reset sequence repeats after release.
- Stall: pix_valid low for 10 cycles in IDLE -> lcd_cs_n=1, lcd_wr_n=1, no bus activity; lcd_d holds its last value.
